// File: rtl/sync_reset_monitor.sv
// Passive observer of a synchronous reset line: measures idle/active run lengths, flags short
// pulses and queues timestamped edge records. Optional stuck-reset timeout: SYNC_RESET_MONITOR_TIMEOUT_EN.
module sync_reset_monitor #(
    parameter bit RESET_POLARITY    = 1'b1,
    parameter int MIN_ACTIVE_CYCLES = 10,
    parameter int MAX_ACTIVE_CYCLES = 1000,
    parameter int CNT_WIDTH         = 16,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mon_reset,
    output logic                 in_reset,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic                 evt_kind,
    output logic [CNT_WIDTH-1:0] evt_cycles,
    output logic                 short_err,
    output logic                 ovf_err,
    output logic [7:0]           drop_cnt,
    output logic                 stuck_err
);

    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int REC_W = CNT_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [31:0]          MIN_LIMIT = 32'(MIN_ACTIVE_CYCLES);
    localparam logic [AW:0]          DEPTH_W   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   count_nxt;
    logic [CNT_WIDTH-1:0]   count_inc;
    logic                   mon_active;

    logic                   push;
    logic                   push_kind;
    logic [CNT_WIDTH-1:0]   push_cycles;
    logic                   short_hit;

    logic [REC_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            occ;
    logic                   full;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;
    logic [REC_W-1:0]       head;

    assign mon_active = (mon_reset == RESET_POLARITY);
    assign count_inc  = (count == CNT_MAX) ? count : count + CNT_ONE;

    // Next-state logic: every edge of the monitored line emits one record and restarts the count.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        push        = 1'b0;
        push_kind   = 1'b0;
        push_cycles = '0;
        short_hit   = 1'b0;
        case (state)
            INIT: begin
                state_nxt = mon_active ? ACTIVE : IDLE;
                count_nxt = CNT_ONE;
            end
            IDLE: begin
                if (mon_active) begin
                    push        = 1'b1;
                    push_kind   = 1'b1;
                    push_cycles = count;
                    state_nxt   = ACTIVE;
                    count_nxt   = CNT_ONE;
                end else begin
                    count_nxt = count_inc;
                end
            end
            ACTIVE: begin
                if (!mon_active) begin
                    push        = 1'b1;
                    push_kind   = 1'b0;
                    push_cycles = count;
                    short_hit   = (32'(count) < MIN_LIMIT);
                    state_nxt   = IDLE;
                    count_nxt   = CNT_ONE;
                end else begin
                    count_nxt = count_inc;
                end
            end
            default: begin
                state_nxt = INIT;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= INIT;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    assign in_reset = (state == ACTIVE);

    // A full FIFO still accepts a push when the head is leaving on the same edge.
    assign full    = (occ == DEPTH_W);
    assign pop     = evt_valid && evt_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push_ok) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_kind, push_cycles};
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_valid  = (occ != '0);
    assign evt_kind   = evt_valid ? head[REC_W-1] : 1'b0;
    assign evt_cycles = evt_valid ? head[CNT_WIDTH-1:0] : '0;

    // Sticky error flags; only block reset clears them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            short_err <= 1'b0;
            ovf_err   <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            if (short_hit) begin
                short_err <= 1'b1;
            end
            if (drop) begin
                ovf_err <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

`ifdef SYNC_RESET_MONITOR_TIMEOUT_EN
    // A limit beyond the counter range trips when the counter saturates.
    localparam logic [CNT_WIDTH-1:0] STUCK_LIMIT =
        (longint'(MAX_ACTIVE_CYCLES) > longint'(CNT_MAX)) ? CNT_MAX : CNT_WIDTH'(MAX_ACTIVE_CYCLES);

    logic stuck_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            stuck_q <= 1'b0;
        end else if (state_nxt == ACTIVE && count_nxt >= STUCK_LIMIT) begin
            stuck_q <= 1'b1;
        end
    end

    assign stuck_err = stuck_q;
`else
    assign stuck_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_reset_monitor.sv
// Scoreboard bench for sync_reset_monitor: stimulus pushes expected edge records, negedge
// monitors pop and compare them; flag checks are directed.
module tb_sync_reset_monitor;

    typedef struct packed {
        logic        kind;
        logic [15:0] cycles;
    } rec_t;

`ifdef SYNC_RESET_MONITOR_TIMEOUT_EN
    localparam logic [31:0] STUCK_EXP = 32'd1;
`else
    localparam logic [31:0] STUCK_EXP = 32'd0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        monReset;
    logic        inReset;
    logic        evtValid;
    logic        evtReady;
    logic        evtKind;
    logic [15:0] evtCycles;
    logic        shortErr;
    logic        ovfErr;
    logic [7:0]  dropCnt;
    logic        stuckErr;

    logic        satReset;
    logic        satMon;
    logic        satInReset;
    logic        satValid;
    logic        satReady;
    logic        satKind;
    logic [3:0]  satCycles;
    logic        satShort;
    logic        satOvf;
    logic [7:0]  satDrop;
    logic        satStuck;

    int   errors = 0;
    int   checks = 0;
    int   inResetCycles = 0;
    rec_t expQ[$];
    rec_t satQ[$];

    always #5 clock = ~clock;

    sync_reset_monitor #(
        .RESET_POLARITY(1'b1), .MIN_ACTIVE_CYCLES(10), .MAX_ACTIVE_CYCLES(50),
        .CNT_WIDTH(16), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset), .mon_reset(monReset), .in_reset(inReset),
        .evt_valid(evtValid), .evt_ready(evtReady), .evt_kind(evtKind),
        .evt_cycles(evtCycles), .short_err(shortErr), .ovf_err(ovfErr),
        .drop_cnt(dropCnt), .stuck_err(stuckErr)
    );

    sync_reset_monitor #(
        .RESET_POLARITY(1'b1), .MIN_ACTIVE_CYCLES(10), .MAX_ACTIVE_CYCLES(1000),
        .CNT_WIDTH(4), .FIFO_DEPTH(4)
    ) dutSat (
        .clock(clock), .reset(satReset), .mon_reset(satMon), .in_reset(satInReset),
        .evt_valid(satValid), .evt_ready(satReady), .evt_kind(satKind),
        .evt_cycles(satCycles), .short_err(satShort), .ovf_err(satOvf),
        .drop_cnt(satDrop), .stuck_err(satStuck)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Holds the monitored line at a level for n sampling edges.
    task automatic applyStimulus(input logic level, input int n);
        monReset = level;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expectRec(input logic kind, input int cycles);
        rec_t r;
        r.kind   = kind;
        r.cycles = 16'(cycles);
        expQ.push_back(r);
    endtask

    task automatic checkResetState();
        checkOutput("rst_in_reset", 32'(inReset), 0);
        checkOutput("rst_evt_valid", 32'(evtValid), 0);
        checkOutput("rst_evt_kind", 32'(evtKind), 0);
        checkOutput("rst_evt_cycles", 32'(evtCycles), 0);
        checkOutput("rst_short_err", 32'(shortErr), 0);
        checkOutput("rst_ovf_err", 32'(ovfErr), 0);
        checkOutput("rst_drop_cnt", 32'(dropCnt), 0);
        checkOutput("rst_stuck_err", 32'(stuckErr), 0);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || satQ.size() != 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput("drain_pending", 32'(expQ.size() + satQ.size()), 0);
    endtask

    // Main scoreboard: pop on transfer, compare the stalled head against the queue front.
    always @(negedge clock) begin
        rec_t e;
        if (reset && evtValid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_record: got kind=%0d cycles=%0d, required none", evtKind, evtCycles);
            end else begin
                e = evtReady ? expQ.pop_front() : expQ[0];
                if (evtKind !== e.kind || evtCycles !== e.cycles) begin
                    errors++;
                    $display("[TB] FAIL %s: got kind=%0d cycles=%0d, required kind=%0d cycles=%0d",
                             evtReady ? "record" : "held_record", evtKind, evtCycles, e.kind, e.cycles);
                end
            end
        end
        if (reset && inReset) inResetCycles++;
    end

    always @(negedge clock) begin
        rec_t e;
        if (satReset && satValid && satReady) begin
            checks++;
            if (satQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sat_unexpected_record: got kind=%0d cycles=%0d, required none", satKind, satCycles);
            end else begin
                e = satQ.pop_front();
                if (satKind !== e.kind || 16'(satCycles) !== e.cycles) begin
                    errors++;
                    $display("[TB] FAIL sat_record: got kind=%0d cycles=%0d, required kind=%0d cycles=%0d",
                             satKind, satCycles, e.kind, e.cycles);
                end
            end
        end
    end

    initial begin
        rec_t r;
        reset    = 1'b0;
        monReset = 1'b1;
        evtReady = 1'b1;
        satReset = 1'b0;
        satMon   = 1'b1;
        satReady = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checkResetState();

        // Basic legal pulse after 5 idle samples.
        reset = 1'b1;
        expectRec(1'b1, 5);  expectRec(1'b0, 10);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 4);
        checkOutput("in_reset_high_cycles", 32'(inResetCycles), 10);
        checkOutput("short_err_legal", 32'(shortErr), 0);

        // Short pulse sets the sticky flag; a later legal pulse leaves it set.
        expectRec(1'b1, 4);  expectRec(1'b0, 3);
        expectRec(1'b1, 6);  expectRec(1'b0, 12);
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 6);
        checkOutput("short_err_set", 32'(shortErr), 1);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 5);
        checkOutput("short_err_sticky", 32'(shortErr), 1);

        // Six edges into a stalled 4-deep FIFO: last two records dropped.
        evtReady = 1'b0;
        expectRec(1'b1, 5);  expectRec(1'b0, 2);
        expectRec(1'b1, 2);  expectRec(1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2);
            applyStimulus(1'b0, 2);
        end
        checkOutput("ovf_err_set", 32'(ovfErr), 1);
        checkOutput("drop_cnt_two", 32'(dropCnt), 2);
        checkOutput("valid_while_full", 32'(evtValid), 1);
        evtReady = 1'b1;
        applyStimulus(1'b0, 6);
        checkOutput("valid_after_drain", 32'(evtValid), 0);
        checkOutput("drained_queue", 32'(expQ.size()), 0);

        // Refill, then push and pop on the same edge while full.
        evtReady = 1'b0;
        expectRec(1'b1, 8);  expectRec(1'b0, 10);
        expectRec(1'b1, 3);  expectRec(1'b0, 10);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 3);
        expectRec(1'b1, 3);  expectRec(1'b0, 10);
        evtReady = 1'b1;
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 3);
        checkOutput("drop_cnt_unchanged", 32'(dropCnt), 2);
        applyStimulus(1'b0, 8);
        checkOutput("simul_push_pop_drained", 32'(expQ.size()), 0);

        // Long assertion: timeout at the 50th active sample, then block reset mid-pulse.
        expectRec(1'b1, 11);
        applyStimulus(1'b1, 49);
        checkOutput("stuck_before_limit", 32'(stuckErr), 0);
        applyStimulus(1'b1, 1);
        checkOutput("stuck_at_limit", 32'(stuckErr), STUCK_EXP);
        applyStimulus(1'b1, 10);
        checkOutput("stuck_sticky", 32'(stuckErr), STUCK_EXP);
        reset = 1'b0;
        applyStimulus(1'b1, 2);
        checkResetState();
        checkOutput("queue_before_rerun", 32'(expQ.size()), 0);

        // Line already active when block reset lifts: INIT goes straight to ACTIVE, no record.
        reset = 1'b1;
        applyStimulus(1'b1, 7);
        checkOutput("init_to_active", 32'(inReset), 1);
        checkOutput("init_no_record", 32'(evtValid), 0);
        expectRec(1'b0, 7);
        applyStimulus(1'b0, 2);
        checkOutput("short_err_after_rerun", 32'(shortErr), 1);

        // 4-bit counters saturate at 15 across a 20-sample pulse.
        satReset = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        checkOutput("sat_in_reset", 32'(satInReset), 1);
        checkOutput("sat_no_init_record", 32'(satValid), 0);
        repeat (18) begin
            @(posedge clock);
            #1;
        end
        r.kind   = 1'b0;
        r.cycles = 16'd15;
        satQ.push_back(r);
        satMon = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checkOutput("sat_released", 32'(satInReset), 0);

        waitDrain(50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
